pck_injct_scheduler: RTL and testbench

Round-robin scheduler that shares one packet-injector endpoint between NR local traffic sources. Each source posts a packet request (VC, size, destination, data). The scheduler picks one eligible source per grant, drives a single-cycle `pck_wr` toward the injector's control interface, and acknowledges the source. It sits between trace/traffic generators and the injector in simulation testbenches. It also screens out malformed requests and counts injected packets.

---
 rtl/pck_injct_scheduler.sv | 166 ++++++++++++++++
 tb/tb_pck_injct_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pck_injct_scheduler.sv
// pck_injct_scheduler
// Round-robin arbiter that shares one packet-injector endpoint between NR
// local traffic sources. In IDLE it picks the first eligible source, starting
// at rr_ptr and wrapping upward. It latches the request into the output
// registers and moves to ISSUE. ISSUE lasts one cycle: a legal request gets an
// injection strobe, and an illegal request is rejected. The source is
// acknowledged in both cases.
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   req_i      [NR]       request valid per source (held until ack_o)
//   req_vc_i   [NR*V]     one-hot VC per source, source n at [n*V +: V]
//   req_size_i [NR*PCK_SIZw], req_dest_i [NR*EAw], req_data_i [NR*DATAw]
//   ack_o      [NR]       one-cycle consume pulse (injected or rejected)
//   err_o      [NR]       one-cycle reject pulse, coincident with ack_o
//   inj_ready_i[V]        per-VC ready from the injector
//   inj_pck_wr_o, inj_vc_o, inj_size_o, inj_endp_addr_o, inj_data_o
//                         injection strobe and fields (fields 0 when no strobe)
//   pck_cnt_o  [32]       packets injected, wraps modulo 2^32
//   busy_o                high while the FSM is in ISSUE
module pck_injct_scheduler #(
  parameter int NR          = 4,
  parameter int V           = 4,
  parameter int PCK_SIZw    = 8,
  parameter int EAw         = 8,
  parameter int DATAw       = 32,
  parameter int MIN_PCK_SIZ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NR-1:0]          req_i,
  input  logic [NR*V-1:0]        req_vc_i,
  input  logic [NR*PCK_SIZw-1:0] req_size_i,
  input  logic [NR*EAw-1:0]      req_dest_i,
  input  logic [NR*DATAw-1:0]    req_data_i,
  output logic [NR-1:0]          ack_o,
  output logic [NR-1:0]          err_o,
  input  logic [V-1:0]           inj_ready_i,
  output logic                   inj_pck_wr_o,
  output logic [V-1:0]           inj_vc_o,
  output logic [PCK_SIZw-1:0]    inj_size_o,
  output logic [EAw-1:0]         inj_endp_addr_o,
  output logic [DATAw-1:0]       inj_data_o,
  output logic [31:0]            pck_cnt_o,
  output logic                   busy_o
);

  localparam int PTRW = $clog2(NR);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state;
  logic [PTRW-1:0]      rr_ptr;
  logic                 wr_q;
  logic [V-1:0]         vc_q;
  logic [PCK_SIZw-1:0]  size_q;
  logic [EAw-1:0]       addr_q;
  logic [DATAw-1:0]     data_q;
  logic [NR-1:0]        ack_q;
  logic [NR-1:0]        err_q;
  logic [31:0]          cnt_q;

  logic [NR-1:0]        legal_n;
  logic [NR-1:0]        eligible_n;
  logic                 found;
  logic [PTRW-1:0]      sel;
  logic [PTRW-1:0]      next_ptr;
  logic [NR-1:0]        sel_onehot;

  function automatic logic vc_onehot(input logic [V-1:0] vc);
    return (vc != '0) && ((vc & (vc - V'(1))) == '0);
  endfunction

  // An illegal request is always eligible so that it gets rejected even when
  // its (possibly bogus) VC never becomes ready.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a bit unassigned
    // (which would infer a latch).
    legal_n    = '0;
    eligible_n = '0;
    for (int n = 0; n < NR; n++) begin
      legal_n[n] = vc_onehot(req_vc_i[n*V +: V]) &&
                   (req_size_i[n*PCK_SIZw +: PCK_SIZw] >= PCK_SIZw'(MIN_PCK_SIZ));
      eligible_n[n] = req_i[n] &&
                      (!legal_n[n] || (|(req_vc_i[n*V +: V] & inj_ready_i)));
    end
  end

  // The search starts at rr_ptr and wraps, so the first hit is the winner.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NR; k++) begin
      if (!found && eligible_n[(int'(rr_ptr) + k) % NR]) begin
        found = 1'b1;
        sel   = PTRW'((int'(rr_ptr) + k) % NR);
      end
    end
  end

  assign next_ptr   = (int'(sel) == NR - 1) ? '0 : sel + PTRW'(1);
  assign sel_onehot = {{(NR-1){1'b0}}, 1'b1} << sel;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      wr_q   <= 1'b0;
      vc_q   <= '0;
      size_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      ack_q  <= '0;
      err_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state  <= ISSUE;
            rr_ptr <= next_ptr;
            ack_q  <= sel_onehot;
            if (legal_n[sel]) begin
              wr_q   <= 1'b1;
              vc_q   <= req_vc_i[int'(sel)*V +: V];
              size_q <= req_size_i[int'(sel)*PCK_SIZw +: PCK_SIZw];
              addr_q <= req_dest_i[int'(sel)*EAw +: EAw];
              data_q <= req_data_i[int'(sel)*DATAw +: DATAw];
            end else begin
              err_q <= sel_onehot;
            end
          end
        end
        ISSUE: begin
          // One cycle only: the injector's ready, seen again in IDLE, gates
          // the next grant, so no extra busy wait is needed.
          state  <= IDLE;
          wr_q   <= 1'b0;
          vc_q   <= '0;
          size_q <= '0;
          addr_q <= '0;
          data_q <= '0;
          ack_q  <= '0;
          err_q  <= '0;
          if (wr_q) cnt_q <= cnt_q + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset raised during ISSUE must suppress that cycle's strobe and ack.
  // The outputs are therefore qualified with reset as well as registered.
  assign inj_pck_wr_o    = wr_q & ~reset;
  assign inj_vc_o        = vc_q & {V{~reset}};
  assign inj_size_o      = size_q & {PCK_SIZw{~reset}};
  assign inj_endp_addr_o = addr_q & {EAw{~reset}};
  assign inj_data_o      = data_q & {DATAw{~reset}};
  assign ack_o           = ack_q & {NR{~reset}};
  assign err_o           = err_q & {NR{~reset}};
  assign busy_o          = (state == ISSUE) & ~reset;
  assign pck_cnt_o       = cnt_q;

endmodule

// File: tb/tb_pck_injct_scheduler.sv
// Directed testbench for pck_injct_scheduler (NR=4, V=4, MIN_PCK_SIZ=2).
// Inputs change on the falling edge, and outputs are checked on the falling
// edge that follows each rising edge.
module tb_pck_injct_scheduler;

  localparam int NR = 4, V = 4, SW = 8, EAW = 8, DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_i;
  logic [NR*V-1:0]  req_vc_i;
  logic [NR*SW-1:0] req_size_i;
  logic [NR*EAW-1:0] req_dest_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    ack_o, err_o;
  logic [V-1:0]     inj_ready_i;
  logic             inj_pck_wr_o;
  logic [V-1:0]     inj_vc_o;
  logic [SW-1:0]    inj_size_o;
  logic [EAW-1:0]   inj_endp_addr_o;
  logic [DW-1:0]    inj_data_o;
  logic [31:0]      pck_cnt_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  pck_injct_scheduler #(
    .NR(NR), .V(V), .PCK_SIZw(SW), .EAw(EAW), .DATAw(DW), .MIN_PCK_SIZ(2)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_vc_i(req_vc_i),
    .req_size_i(req_size_i), .req_dest_i(req_dest_i), .req_data_i(req_data_i),
    .ack_o(ack_o), .err_o(err_o), .inj_ready_i(inj_ready_i),
    .inj_pck_wr_o(inj_pck_wr_o), .inj_vc_o(inj_vc_o), .inj_size_o(inj_size_o),
    .inj_endp_addr_o(inj_endp_addr_o), .inj_data_o(inj_data_o),
    .pck_cnt_o(pck_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int n, input logic [V-1:0] vc, input logic [SW-1:0] sz,
                         input logic [EAW-1:0] dst, input logic [DW-1:0] dat);
    req_vc_i[n*V +: V]       = vc;
    req_size_i[n*SW +: SW]   = sz;
    req_dest_i[n*EAW +: EAW] = dst;
    req_data_i[n*DW +: DW]   = dat;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr"},  64'(inj_pck_wr_o), 64'd0);
    chk({tag, "_ack"}, 64'(ack_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
  endtask

  logic [NR-1:0] rr_ack [4];
  logic [V-1:0]  rr_vc  [4];

  initial begin
    reset = 1'b1;
    req_i = '0; req_vc_i = '0; req_size_i = '0; req_dest_i = '0; req_data_i = '0;
    inj_ready_i = '0;
    @(negedge clk);
    tick();
    tick();

    // Reset state.
    chk("rst_wr",   64'(inj_pck_wr_o), 64'd0);
    chk("rst_ack",  64'(ack_o), 64'd0);
    chk("rst_err",  64'(err_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cnt",  64'(pck_cnt_o), 64'd0);
    chk("rst_vc",   64'(inj_vc_o), 64'd0);
    chk("rst_data", 64'(inj_data_o), 64'd0);
    chk("rst_ptr",  64'(dut.rr_ptr), 64'd0);
    reset = 1'b0;
    tick();
    chk_idle("idle_noreq");

    // Round robin: sources 0, 1 and 3 request continuously, all VCs ready.
    set_src(0, 4'b0001, 8'd4, 8'd10, 32'h100);
    set_src(1, 4'b0010, 8'd4, 8'd11, 32'h101);
    set_src(3, 4'b1000, 8'd4, 8'd13, 32'h103);
    inj_ready_i = 4'hF;
    req_i = 4'b1011;
    rr_ack[0] = 4'b0001; rr_ack[1] = 4'b0010; rr_ack[2] = 4'b1000; rr_ack[3] = 4'b0001;
    rr_vc[0]  = 4'b0001; rr_vc[1]  = 4'b0010; rr_vc[2]  = 4'b1000; rr_vc[3]  = 4'b0001;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("rr%0d_wr", g),   64'(inj_pck_wr_o), 64'd1);
      chk($sformatf("rr%0d_ack", g),  64'(ack_o), 64'(rr_ack[g]));
      chk($sformatf("rr%0d_vc", g),   64'(inj_vc_o), 64'(rr_vc[g]));
      chk($sformatf("rr%0d_busy", g), 64'(busy_o), 64'd1);
      if (g == 3) req_i = '0;
      tick();
      chk($sformatf("rr%0d_gap_wr", g), 64'(inj_pck_wr_o), 64'd0);
    end
    chk("rr_cnt", 64'(pck_cnt_o), 64'd4);

    // Single request from source 1 (rr_ptr is now 1).
    set_src(1, 4'b0010, 8'd3, 8'd5, 32'hA5);
    req_i = 4'b0010;
    tick();
    chk("single_wr",   64'(inj_pck_wr_o), 64'd1);
    chk("single_vc",   64'(inj_vc_o), 64'h2);
    chk("single_size", 64'(inj_size_o), 64'd3);
    chk("single_addr", 64'(inj_endp_addr_o), 64'd5);
    chk("single_data", 64'(inj_data_o), 64'hA5);
    chk("single_ack",  64'(ack_o), 64'b0010);
    chk("single_err",  64'(err_o), 64'd0);
    req_i = '0;
    tick();
    chk_idle("single_after");
    chk("single_cnt",   64'(pck_cnt_o), 64'd5);
    chk("single_vc_0",  64'(inj_vc_o), 64'd0);

    // Blocked VC: source 0 on VC0, source 2 on VC1, only VC1 ready.
    set_src(0, 4'b0001, 8'd6, 8'd20, 32'hB0);
    set_src(2, 4'b0010, 8'd7, 8'd22, 32'hB2);
    inj_ready_i = 4'b0010;
    req_i = 4'b0101;
    tick();
    chk("blk_ack2", 64'(ack_o), 64'b0100);
    chk("blk_addr", 64'(inj_endp_addr_o), 64'd22);
    req_i = 4'b0001;
    tick();
    tick();
    chk_idle("blk_wait");
    chk("blk_busy", 64'(busy_o), 64'd0);
    inj_ready_i = 4'b0011;
    tick();
    chk("blk_ack0", 64'(ack_o), 64'b0001);
    chk("blk_size", 64'(inj_size_o), 64'd6);
    req_i = '0;
    tick();
    chk("blk_cnt", 64'(pck_cnt_o), 64'd7);

    // Rejects with no VC ready: undersized packet, then a two-hot VC.
    inj_ready_i = 4'b0000;
    set_src(2, 4'b0100, 8'd1, 8'd30, 32'hC2);
    req_i = 4'b0100;
    tick();
    chk("rej_sz_ack", 64'(ack_o), 64'b0100);
    chk("rej_sz_err", 64'(err_o), 64'b0100);
    chk("rej_sz_wr",  64'(inj_pck_wr_o), 64'd0);
    chk("rej_sz_vc",  64'(inj_vc_o), 64'd0);
    req_i = '0;
    tick();
    chk("rej_sz_cnt", 64'(pck_cnt_o), 64'd7);
    set_src(2, 4'b0110, 8'd4, 8'd31, 32'hC3);
    req_i = 4'b0100;
    tick();
    chk("rej_vc_ack", 64'(ack_o), 64'b0100);
    chk("rej_vc_err", 64'(err_o), 64'b0100);
    chk("rej_vc_wr",  64'(inj_pck_wr_o), 64'd0);
    req_i = '0;
    tick();
    chk("rej_vc_cnt", 64'(pck_cnt_o), 64'd7);

    // Minimum legal size waits for ready instead of being rejected.
    set_src(1, 4'b0001, 8'd2, 8'd40, 32'hD1);
    req_i = 4'b0010;
    tick();
    chk_idle("min_blocked");
    inj_ready_i = 4'b0001;
    tick();
    chk("min_wr",   64'(inj_pck_wr_o), 64'd1);
    chk("min_size", 64'(inj_size_o), 64'd2);
    chk("min_err",  64'(err_o), 64'd0);
    req_i = '0;
    tick();
    chk("min_cnt", 64'(pck_cnt_o), 64'd8);

    // Reset raised during ISSUE.
    inj_ready_i = 4'hF;
    set_src(0, 4'b0001, 8'd5, 8'd50, 32'hE0);
    req_i = 4'b0001;
    tick();
    chk("rsti_pre_wr", 64'(inj_pck_wr_o), 64'd1);
    reset = 1'b1;
    #1;
    chk("rsti_wr_sup",  64'(inj_pck_wr_o), 64'd0);
    chk("rsti_ack_sup", 64'(ack_o), 64'd0);
    @(negedge clk);
    tick();
    chk_idle("rsti_after");
    chk("rsti_busy", 64'(busy_o), 64'd0);
    chk("rsti_ptr",  64'(dut.rr_ptr), 64'd0);
    chk("rsti_cnt",  64'(pck_cnt_o), 64'd0);
    reset = 1'b0;
    tick();
    chk("rsti_regrant_ack", 64'(ack_o), 64'b0001);
    chk("rsti_regrant_wr",  64'(inj_pck_wr_o), 64'd1);
    req_i = '0;
    tick();
    chk("rsti_cnt1", 64'(pck_cnt_o), 64'd1);

    // Counter wrap.
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", 64'(pck_cnt_o), 64'hFFFF_FFFF);
    set_src(3, 4'b1000, 8'd9, 8'd60, 32'hF3);
    req_i = 4'b1000;
    tick();
    chk("wrap_ack", 64'(ack_o), 64'b1000);
    req_i = '0;
    tick();
    chk("wrap_cnt", 64'(pck_cnt_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
